ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, at least 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pc_addr_o  output  32  current fetch PC, driven to the predictor PC-index input and to the instruction memory.
REQ-006 SHALL have port inst_i  input  32  instruction at pc_addr_o, combinational from the instruction memory.
REQ-007 SHALL have ports pr_i  input  1 and pr_addr_i  input  32: taken-prediction and predicted target for pc_addr_o.
REQ-008 SHALL have ports br_i  input  1 and br_addr_i  input  32: mispredict redirect and correct target.
REQ-009 SHALL have port fetch_en_o  output  1  high in a cycle whose fetch is enqueued.
REQ-010 SHALL have ports deq_valid_o  output  1 and deq_ready_i  input  1: downstream handshake.
REQ-011 SHALL have ports deq_pc_o  output  32, deq_inst_o  output  32, deq_pr_o  output  1 and deq_pr_addr_o  output  32: the head entry.
REQ-012 SHALL have port count_o  output  log2(DEPTH)+1  current number of occupied entries.

Function
REQ-013 SHALL set fetch_en_o = rst_n & !br_i & (count < DEPTH); a full queue SHALL NOT fetch, even with a concurrent dequeue.
REQ-014 SHALL, when fetch_en_o is high, write {pc_addr_o, inst_i, pr_i, pr_addr_i} at the tail and advance the tail pointer modulo DEPTH.
REQ-015 SHALL, when fetch_en_o is high, load the next PC as pr_addr_i if pr_i is high, else pc_addr_o+4 (32-bit wrap, FFFF_FFFC+4 = 0).
REQ-016 SHALL hold pc_addr_o when neither fetch_en_o nor br_i is high.
REQ-017 SHALL, on br_i, load pc_addr_o <= br_addr_i unmodified (no alignment check), set head, tail and count to 0, and neither enqueue nor dequeue.
REQ-018 SHALL drive deq_valid_o = (count != 0) & !br_i; deq_* SHALL present the head entry combinationally.
REQ-019 SHALL pop the head (head pointer +1 modulo DEPTH) when deq_valid_o & deq_ready_i.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-021 SHALL keep deq_* data stable while deq_valid_o is high and deq_ready_i is low.
REQ-022 SHALL give an enqueued entry a latency of exactly one cycle, fetch to deq_valid_o, when the queue is empty (non-bypass build).

Reset
REQ-023 SHALL, when rst_n is low at a clk edge, set pc_addr_o=RESET_PC, head=tail=count=0; reset SHALL take priority over br_i and fetch.
REQ-024 SHALL force deq_valid_o=0 and fetch_en_o=0 while rst_n is low; queue storage contents SHALL NOT need clearing.
REQ-025 SHALL discard an in-progress fetch or dequeue when reset is asserted mid-operation; the first fetch after release is at RESET_PC.

Configuration
REQ-026 SHALL, with IFETCH_BYPASS_EN defined, drive the fetched entry onto deq_* with deq_valid_o high in the same cycle when count==0 and fetch_en_o is high; if deq_ready_i is also high, the entry SHALL NOT be written and count SHALL stay 0.
REQ-027 SHALL, without IFETCH_BYPASS_EN, present entries only from storage (REQ-022 latency).

Verification
REQ-028 SHALL cover: reset release, deq_ready_i=1, no prediction -> pc_addr_o sequence 0,4,8,C; deq_pc_o 0 valid one cycle after the first fetch.
REQ-029 SHALL cover: pr_i=1, pr_addr_i=0x40 at pc 0x8 -> next pc_addr_o=0x40; the entry carries deq_pr_o=1, deq_pr_addr_o=0x40.
REQ-030 SHALL cover: deq_ready_i=0 for 10 cycles, DEPTH=8 -> count_o reaches 8, fetch_en_o drops, pc_addr_o holds at 0x20.
REQ-031 SHALL cover: count=5 and br_i=1, br_addr_i=0x100 -> next cycle count_o=0, deq_valid_o=0, pc_addr_o=0x100; deq_valid_o is 0 during the br_i cycle.
REQ-032 SHALL cover: rst_n low for one cycle while br_i=1 and count=3 -> pc_addr_o=RESET_PC, count_o=0.
REQ-033 SHALL cover: with IFETCH_BYPASS_EN, empty queue, fetch at 0x0 with deq_ready_i=1 -> deq_pc_o=0x0 valid the same cycle, count_o stays 0.

Source files
------------

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch PC generator feeding a DEPTH-entry fetch queue.
// Optional same-cycle bypass of an empty queue: define IFETCH_BYPASS_EN.
module ifetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                pc_addr_o,
  input  logic [31:0]                inst_i,
  input  logic                       pr_i,
  input  logic [31:0]                pr_addr_i,
  input  logic                       br_i,
  input  logic [31:0]                br_addr_i,
  output logic                       fetch_en_o,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [31:0]                deq_pc_o,
  output logic [31:0]                deq_inst_o,
  output logic                       deq_pr_o,
  output logic [31:0]                deq_pr_addr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic        pr_mem   [DEPTH];
  logic [31:0] pra_mem  [DEPTH];

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, bypass, push, pop;

  assign empty      = (count_q == '0);
  assign fetch_en_o = rst_n & ~br_i & (count_q != CW'(DEPTH));

`ifdef IFETCH_BYPASS_EN
  assign bypass = empty & fetch_en_o;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid_o   = rst_n & ~br_i & (~empty | bypass);
  assign deq_pc_o      = bypass ? pc_addr_o : pc_mem[head_q];
  assign deq_inst_o    = bypass ? inst_i    : inst_mem[head_q];
  assign deq_pr_o      = bypass ? pr_i      : pr_mem[head_q];
  assign deq_pr_addr_o = bypass ? pr_addr_i : pra_mem[head_q];

  // A bypassed entry consumed in the same cycle never touches storage.
  assign push = fetch_en_o & ~(bypass & deq_ready_i);
  assign pop  = deq_valid_o & deq_ready_i & ~bypass;

  assign pc_addr_o = pc_q;
  assign count_o   = count_q;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (br_i) begin
      pc_d    = br_addr_i;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fetch_en_o) pc_d = pr_i ? pr_addr_i : pc_q + 32'd4;
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= pc_addr_o;
      inst_mem[tail_q] <= inst_i;
      pr_mem[tail_q]   <= pr_i;
      pra_mem[tail_q]  <= pr_addr_i;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed checks of ifetch_queue (DEPTH=8, RESET_PC=0).
// Bypass expectations apply when IFETCH_BYPASS_EN is defined.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr_o;
  logic [31:0] inst_i;
  logic        pr_i;
  logic [31:0] pr_addr_i;
  logic        br_i;
  logic [31:0] br_addr_i;
  logic        fetch_en_o;
  logic        deq_valid_o;
  logic        deq_ready_i;
  logic [31:0] deq_pc_o;
  logic [31:0] deq_inst_o;
  logic        deq_pr_o;
  logic [31:0] deq_pr_addr_o;
  logic [3:0]  count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: a recognisable pattern derived from the address.
  assign inst_i = pc_addr_o ^ 32'hA5A5_0000;

  ifetch_queue #(.DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_addr_o     (pc_addr_o),
    .inst_i        (inst_i),
    .pr_i          (pr_i),
    .pr_addr_i     (pr_addr_i),
    .br_i          (br_i),
    .br_addr_i     (br_addr_i),
    .fetch_en_o    (fetch_en_o),
    .deq_valid_o   (deq_valid_o),
    .deq_ready_i   (deq_ready_i),
    .deq_pc_o      (deq_pc_o),
    .deq_inst_o    (deq_inst_o),
    .deq_pr_o      (deq_pr_o),
    .deq_pr_addr_o (deq_pr_addr_o),
    .count_o       (count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; deq_ready_i = 1'b1;
    pr_i = 1'b0; pr_addr_i = '0; br_i = 1'b0; br_addr_i = '0;
    tick; tick;
    check("rst_pc", pc_addr_o, 32'h0);
    check("rst_count", count_o, 32'd0);
    check("rst_deq_valid", deq_valid_o, 32'd0);
    check("rst_fetch_en", fetch_en_o, 32'd0);

`ifdef IFETCH_BYPASS_EN
    rst_n = 1'b1; #1;
    check("byp_valid_same_cycle", deq_valid_o, 32'd1);
    check("byp_pc_same_cycle", deq_pc_o, 32'h0);
    check("byp_inst_same_cycle", deq_inst_o, 32'hA5A5_0000);
    tick;
    check("byp_count_stays0", count_o, 32'd0);
    check("byp_pc4", pc_addr_o, 32'h4);
    check("byp_deq_pc4", deq_pc_o, 32'h4);
    deq_ready_i = 1'b0; #1;
    check("byp_valid_stall", deq_valid_o, 32'd1);
    tick;
    check("byp_count_written", count_o, 32'd1);
    check("byp_pc8", pc_addr_o, 32'h8);
    check("byp_stored_pc", deq_pc_o, 32'h4);
    check("byp_stored_inst", deq_inst_o, 32'hA5A5_0004);
`else
    rst_n = 1'b1; #1;
    check("rel_fetch_en", fetch_en_o, 32'd1);
    check("rel_no_same_cycle", deq_valid_o, 32'd0);
    tick;
    check("seq_pc4", pc_addr_o, 32'h4);
    check("seq_count1", count_o, 32'd1);
    check("seq_valid", deq_valid_o, 32'd1);
    check("seq_deq_pc0", deq_pc_o, 32'h0);
    check("seq_deq_inst0", deq_inst_o, 32'hA5A5_0000);
    tick;
    check("seq_pc8", pc_addr_o, 32'h8);
    check("seq_deq_pc4", deq_pc_o, 32'h4);
    check("seq_count_pushpop", count_o, 32'd1);
    tick;
    check("seq_pcC", pc_addr_o, 32'hC);
    check("seq_deq_pc8", deq_pc_o, 32'h8);

    br_i = 1'b1; br_addr_i = 32'h8; #1;
    check("br_valid_low", deq_valid_o, 32'd0);
    check("br_fetch_low", fetch_en_o, 32'd0);
    tick; br_i = 1'b0; #1;
    check("br_pc8", pc_addr_o, 32'h8);
    check("br_count0", count_o, 32'd0);

    pr_i = 1'b1; pr_addr_i = 32'h40;
    tick; pr_i = 1'b0; pr_addr_i = 32'h0; #1;
    check("pred_pc40", pc_addr_o, 32'h40);
    check("pred_deq_pc", deq_pc_o, 32'h8);
    check("pred_deq_pr", deq_pr_o, 32'd1);
    check("pred_deq_pr_addr", deq_pr_addr_o, 32'h40);

    br_i = 1'b1; br_addr_i = 32'h0;
    tick; br_i = 1'b0; deq_ready_i = 1'b0; #1;
    check("fill_start_pc", pc_addr_o, 32'h0);
    repeat (8) tick;
    check("full_count8", count_o, 32'd8);
    check("full_fetch_low", fetch_en_o, 32'd0);
    check("full_pc20", pc_addr_o, 32'h20);
    repeat (2) tick;
    check("full_hold_pc", pc_addr_o, 32'h20);
    check("full_hold_count", count_o, 32'd8);
    check("stall_deq_pc", deq_pc_o, 32'h0);
    check("stall_valid", deq_valid_o, 32'd1);
    deq_ready_i = 1'b1; #1;
    check("full_pop_no_fetch", fetch_en_o, 32'd0);
    tick;
    check("full_pop_count7", count_o, 32'd7);
    check("full_pop_pc", pc_addr_o, 32'h20);
    check("full_pop_deq_pc4", deq_pc_o, 32'h4);

    br_i = 1'b1; br_addr_i = 32'h0;
    tick; br_i = 1'b0; deq_ready_i = 1'b0; #1;
    repeat (5) tick;
    check("c5_count", count_o, 32'd5);
    check("c5_pc", pc_addr_o, 32'h14);
    br_i = 1'b1; br_addr_i = 32'h100; #1;
    check("c5_br_valid_low", deq_valid_o, 32'd0);
    tick; br_i = 1'b0; #1;
    check("c5_br_count0", count_o, 32'd0);
    check("c5_br_valid0", deq_valid_o, 32'd0);
    check("c5_br_pc100", pc_addr_o, 32'h100);

    repeat (3) tick;
    check("c3_count", count_o, 32'd3);
    check("c3_pc", pc_addr_o, 32'h10C);
    rst_n = 1'b0; br_i = 1'b1; br_addr_i = 32'h200; #1;
    check("rstbr_valid_low", deq_valid_o, 32'd0);
    check("rstbr_fetch_low", fetch_en_o, 32'd0);
    tick; rst_n = 1'b1; br_i = 1'b0; deq_ready_i = 1'b1; #1;
    check("rstbr_pc", pc_addr_o, 32'h0);
    check("rstbr_count", count_o, 32'd0);
    tick;
    check("rstbr_first_fetch", deq_pc_o, 32'h0);
    check("rstbr_valid", deq_valid_o, 32'd1);

    br_i = 1'b1; br_addr_i = 32'hFFFF_FFFC;
    tick; br_i = 1'b0; #1;
    check("wrap_pc_top", pc_addr_o, 32'hFFFF_FFFC);
    tick;
    check("wrap_pc0", pc_addr_o, 32'h0);
    check("wrap_deq_pc", deq_pc_o, 32'hFFFF_FFFC);
    check("wrap_deq_inst", deq_inst_o, 32'h5A5A_FFFC);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
